// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel clamped widths.
// Optional slew limiter enabled by defining SERVO_PWM_SLEW_EN; default build loads targets directly.
module servo_pwm_multi #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned FRAME_HZ  = 50,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned W_MIN     = 50_000,
    parameter int unsigned W_MAX     = 100_000,
    parameter int unsigned RESET_W   = 75_000,
    parameter int unsigned SLEW_STEP = 1_000,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_width,
    output logic                wr_ready,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic                busy
);

    localparam int unsigned      FRAME_LEN = CLK_HZ / FRAME_HZ;
    localparam int unsigned      SUM_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WMIN_C    = CNT_W'(W_MIN);
    localparam logic [CNT_W-1:0] WMAX_C    = CNT_W'(W_MAX);
    localparam logic [CNT_W-1:0] RESET_C   = CNT_W'(RESET_W);

`ifdef SERVO_PWM_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // Without slew the step is unbounded, so every frame load lands straight on the target.
    localparam logic [CNT_W:0] STEP = SLEW_ON ? SUM_W'(SLEW_STEP) : '1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tgt_q [CHANNELS];
    logic [CNT_W-1:0]    tgt_d [CHANNELS];
    logic [CNT_W-1:0]    cur_q [CHANNELS];
    logic [CNT_W-1:0]    cur_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                wr_ready_q, frame_start_q, busy_q, busy_d;
    logic                load, wr_fire;
    logic [CNT_W-1:0]    wr_clamped;

    function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w);
        if (w < WMIN_C) return WMIN_C;
        if (w > WMAX_C) return WMAX_C;
        return w;
    endfunction

    // Differences are taken one bit wider so no step can wrap past the target.
    function automatic logic [CNT_W-1:0] slew_next(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] c, t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) return (t - c > STEP) ? CNT_W'(c + STEP) : tgt;
        return (c - t > STEP) ? CNT_W'(c - STEP) : tgt;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        load       = (cnt_q == LAST_CNT);
        wr_fire    = wr_valid && wr_ready_q;
        wr_clamped = clamp_width(wr_width);
        pwm_d      = '0;
        busy_d     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            tgt_d[i] = tgt_q[i];
            if (wr_fire && (int'(wr_ch) == i)) tgt_d[i] = wr_clamped;
            cur_d[i] = load ? slew_next(cur_q[i], tgt_q[i]) : cur_q[i];
            // Outputs are computed from next-state so the registered pwm lines up with cnt.
            pwm_d[i] = (cnt_d < cur_d[i]);
            busy_d   = busy_d | (cur_d[i] != tgt_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt_q         <= LAST_CNT;
            wr_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            pwm_q         <= '0;
            // NOTE: tgt/cur are a few flops per channel, not a RAM, so they reset like any register.
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= RESET_C;
                cur_q[i] <= RESET_C;
            end
        end else begin
            cnt_q         <= cnt_d;
            wr_ready_q    <= (cnt_d != LAST_CNT);
            frame_start_q <= (cnt_d == '0);
            busy_q        <= busy_d;
            pwm_q         <= pwm_d;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign wr_ready    = wr_ready_q;
    assign pwm         = pwm_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: a spec-level reference model pushes expected
// per-frame widths into a scoreboard queue; a negedge monitor measures and pops them.
module tb_servo_pwm_multi;

    localparam int CH      = 4;
    localparam int CNT_W   = 20;
    localparam int FL      = 100;
    localparam int W_MIN   = 10;
    localparam int W_MAX   = 20;
    localparam int RESET_W = 15;
    localparam int STEP    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic [CNT_W-1:0] wr_width = '0;
    logic             wr_ready;
    logic [CH-1:0]    pwm;
    logic             frame_start;
    logic             busy;

    // Three-channel instance: a 2-bit wr_ch can address the nonexistent channel 3.
    logic             wr3_valid = 1'b0;
    logic [1:0]       wr3_ch = '0;
    logic [CNT_W-1:0] wr3_width = '0;
    logic             wr3_ready;
    logic [2:0]       pwm3;
    logic             fs3;
    logic             busy3;

    servo_pwm_multi #(
        .CLK_HZ(1000), .FRAME_HZ(10), .CHANNELS(CH), .CNT_W(CNT_W),
        .W_MIN(W_MIN), .W_MAX(W_MAX), .RESET_W(RESET_W), .SLEW_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_width(wr_width),
        .wr_ready(wr_ready), .pwm(pwm), .frame_start(frame_start), .busy(busy)
    );

    servo_pwm_multi #(
        .CLK_HZ(1000), .FRAME_HZ(10), .CHANNELS(3), .CNT_W(CNT_W),
        .W_MIN(W_MIN), .W_MAX(W_MAX), .RESET_W(RESET_W), .SLEW_STEP(STEP)
    ) dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr3_valid), .wr_ch(wr3_ch), .wr_width(wr3_width),
        .wr_ready(wr3_ready), .pwm(pwm3), .frame_start(fs3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (updated at posedge from bench inputs only)
    typedef logic [CH-1:0][7:0] widths_t;
    widths_t exp_q[$];

    int   m_cnt = FL - 1;
    int   m_tgt[CH];
    int   m_cur[CH];
    logic m_rst = 1'b1;
    logic m_ready = 1'b0;
    logic m_fs = 1'b0;
    logic m_busy = 1'b0;

    function automatic int clamp_m(input int w);
        if (w < W_MIN) return W_MIN;
        if (w > W_MAX) return W_MAX;
        return w;
    endfunction

    function automatic int next_cur(input int c, input int t);
`ifdef SERVO_PWM_SLEW_EN
        if (t - c > STEP) return c + STEP;
        if (c - t > STEP) return c - STEP;
        return t;
`else
        if (c != t) return t;
        return c;
`endif
    endfunction

    always @(posedge clk) begin
        widths_t e;
        e = '0;
        if (rst) begin
            m_rst   = 1'b1;
            m_cnt   = FL - 1;
            m_ready = 1'b0;
            m_fs    = 1'b0;
            m_busy  = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_tgt[i] = RESET_W;
                m_cur[i] = RESET_W;
            end
        end else begin
            m_rst = 1'b0;
            if (wr_valid && m_ready) m_tgt[wr_ch] = clamp_m(int'(wr_width));
            if (m_cnt == FL - 1) begin
                m_cnt = 0;
                for (int i = 0; i < CH; i++) begin
                    m_cur[i] = next_cur(m_cur[i], m_tgt[i]);
                    e[i] = 8'(m_cur[i]);
                end
                exp_q.push_back(e);
            end else begin
                m_cnt++;
            end
            m_ready = (m_cnt != FL - 1);
            m_fs    = (m_cnt == 0);
            m_busy  = 1'b0;
            for (int i = 0; i < CH; i++) if (m_cur[i] != m_tgt[i]) m_busy = 1'b1;
        end
    end

    // ---------------- monitor (negedge, away from the active edge)
    bit measuring = 0;
    int fidx = 0;
    int hi_cnt[CH];
    int end_idx[CH];
    int meas_w[CH];

    task automatic close_frame();
        widths_t e;
        if (exp_q.size() == 0) begin
            check("sb_depth", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < CH; i++) begin
            check($sformatf("width%0d", i), hi_cnt[i], int'(e[i]));
            check($sformatf("contig%0d", i), end_idx[i], int'(e[i]));
            meas_w[i] = hi_cnt[i];
        end
    endtask

    always @(negedge clk) begin
        check("frame_start", int'(frame_start), int'(m_fs));
        check("wr_ready", int'(wr_ready), int'(m_ready));
        check("busy", int'(busy), int'(m_busy));
        if (m_rst) begin
            check("pwm_in_reset", int'(pwm), 0);
            measuring = 0;
            exp_q.delete();
        end else begin
            if (frame_start) begin
                if (measuring) close_frame();
                measuring = 1;
                fidx = 0;
                for (int i = 0; i < CH; i++) begin
                    hi_cnt[i]  = 0;
                    end_idx[i] = 0;
                end
            end
            if (measuring) begin
                for (int i = 0; i < CH; i++) begin
                    if (pwm[i]) begin
                        hi_cnt[i]++;
                        end_idx[i] = fidx + 1;
                    end
                end
                fidx++;
            end
        end
    end

    // ---------------- stimulus helpers (caller is always at a negedge)
    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != c && n < 300);
        if (m_cnt != c) check("wait_cnt", m_cnt, c);
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [CNT_W-1:0] w, output int waits);
        logic r;
        waits    = 0;
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_width = w;
        forever begin
            r = wr_ready;
            @(negedge clk);
            if (r) break;
            waits++;
            if (waits > 300) begin
                check("wr_timeout", waits, 0);
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    logic [CNT_W-1:0] clamp_in  [6] = '{20'd3, 20'd500, 20'd10, 20'hFFFFF, 20'd0, 20'd20};
    int               clamp_exp [6] = '{10, 20, 10, 20, 10, 20};

    initial begin
        int waits;
        int n;

        // 1: reset and release
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_fs", int'(frame_start), 1);
        check("rel_pwm", int'(pwm), 4'hF);
        wait_cnt(50);
        wait_cnt(50);
        for (int i = 0; i < CH; i++) check($sformatf("t1_w%0d", i), meas_w[i], RESET_W);

        // 2: clamp boundaries on ch1
        for (int k = 0; k < 6; k++) begin
            do_write(2'd1, clamp_in[k], waits);
            wait_cnt(50);
            wait_cnt(50);
`ifndef SERVO_PWM_SLEW_EN
            check($sformatf("t2_clamp%0d", k), meas_w[1], clamp_exp[k]);
`endif
            check("t2_ch0", meas_w[0], RESET_W);
        end

        // 3: write presented in the load cycle waits one cycle
        wait_cnt(FL - 1);
        check("t3_ready", int'(wr_ready), 0);
        do_write(2'd2, 20'd18, waits);
        check("t3_waits", waits, 1);
        wait_cnt(50);
        wait_cnt(50);
        check("t3_cur_frame", meas_w[2], RESET_W);
        wait_cnt(50);
`ifdef SERVO_PWM_SLEW_EN
        check("t3_next_frame", meas_w[2], 17);
`else
        check("t3_next_frame", meas_w[2], 18);
`endif

        // 4: ch0 15 -> 20, starting from an idle design
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        if (busy) check("t4_idle", int'(busy), 0);
        wait_cnt(50);
        do_write(2'd0, 20'd20, waits);
        check("t4_busy_set", int'(busy), 1);
        wait_cnt(50);
`ifdef SERVO_PWM_SLEW_EN
        wait_cnt(50);
        check("t4_w1", meas_w[0], 17);
        check("t4_busy_mid", int'(busy), 1);
        wait_cnt(50);
        check("t4_w2", meas_w[0], 19);
        check("t4_busy_done", int'(busy), 0);
        wait_cnt(50);
        check("t4_w3", meas_w[0], 20);
`else
        check("t4_busy_done", int'(busy), 0);
        wait_cnt(50);
        check("t4_w1", meas_w[0], 20);
`endif

        // 5: out-of-range channel on the 3-channel instance, then a back-to-back burst
        wait_cnt(10);
        wr3_valid = 1'b1;
        wr3_ch    = 2'd3;
        wr3_width = 20'd12;
        check("x3_ready", int'(wr3_ready), 1);
        @(negedge clk);
        wr3_valid = 1'b0;
        check("x3_busy_acc", int'(busy3), 0);
        do_write(2'd3, 20'd11, waits);
        do_write(2'd3, 20'd19, waits);
        check("t5_b2b_waits", waits, 0);
        wait_cnt(50);
        wait_cnt(50);
        wait_cnt(13);
        check("x3_pwm", int'(pwm3), 3'b111);
        check("x3_busy", int'(busy3), 0);
        wait_cnt(50);
        check("t5_ch0", meas_w[0], 20);
        check("t5_ch1", meas_w[1], 20);
        check("t5_ch2", meas_w[2], 18);
`ifdef SERVO_PWM_SLEW_EN
        check("t5_ch3", meas_w[3], 17);
`else
        check("t5_ch3", meas_w[3], 19);
`endif

        // 6: reset in the middle of a pulse
        wait_cnt(5);
        check("t6_pwm0_high", int'(pwm[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_cut", int'(pwm), 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rel_fs", int'(frame_start), 1);
        check("t6_rel_pwm", int'(pwm), 4'hF);
        wait_cnt(50);
        wait_cnt(50);
        for (int i = 0; i < CH; i++) check($sformatf("t6_w%0d", i), meas_w[i], RESET_W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
